// File: rtl/rgbw_pkg.sv
// rtl/rgbw_pkg.sv - shared types and constants for the RGBW fade slew limiter
package rgbw_pkg;

  localparam int DUTY_W       = 8;
  localparam int STEP_DIV_DEF = 12000;
  localparam int STEP_DEF     = 1;

  typedef enum logic {
    FADE_IDLE = 1'b0,
    FADE_RAMP = 1'b1
  } fade_state_e;

  // Cheap gamma curve: (d*(d+1))>>8 keeps 0, 128->64 and 255 exact
  function automatic logic [DUTY_W-1:0] gamma8(input logic [DUTY_W-1:0] d);
    logic [15:0] p;
    p = 16'(d) * (16'(d) + 16'd1);
    return 8'(p >> 8);
  endfunction

endpackage

// File: rtl/rgbw_fade_slew_if.sv
// rtl/rgbw_fade_slew_if.sv - target/duty bundle between colorGen, fade limiter and pwmGen
interface rgbw_fade_slew_if;
  import rgbw_pkg::*;

  logic              target_valid;
  logic [DUTY_W-1:0] rTarget;
  logic [DUTY_W-1:0] gTarget;
  logic [DUTY_W-1:0] bTarget;
  logic [DUTY_W-1:0] wTarget;
  logic              bypass;
  logic [DUTY_W-1:0] rDuty;
  logic [DUTY_W-1:0] gDuty;
  logic [DUTY_W-1:0] bDuty;
  logic [DUTY_W-1:0] wDuty;
  logic              settled;

  modport master (
    output target_valid, rTarget, gTarget, bTarget, wTarget, bypass,
    input  rDuty, gDuty, bDuty, wDuty, settled
  );

  modport slave (
    input  target_valid, rTarget, gTarget, bTarget, wTarget, bypass,
    output rDuty, gDuty, bDuty, wDuty, settled
  );

endinterface

// File: rtl/rgbw_fade_channel.sv
// rtl/rgbw_fade_channel.sv - one colour channel: target latch, duty register, clamped step
module rgbw_fade_channel
  import rgbw_pkg::*;
#(
  parameter int STEP = STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step_en,
  input  logic              bypass,
  input  logic [DUTY_W-1:0] target_in,
  output logic [DUTY_W-1:0] duty,
  output logic              at_target_next
);

  localparam logic [DUTY_W:0]   STEP9 = 9'(STEP);
  localparam logic [DUTY_W-1:0] STEP8 = 8'(STEP);

  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W:0]   up_diff;
  logic [DUTY_W:0]   dn_diff;

  // Next target/duty: bypass copies the target, otherwise step toward it without overshoot
  always_comb begin
    target_d = load ? target_in : target_q;
    duty_d   = duty_q;
    up_diff  = {1'b0, target_q} - {1'b0, duty_q};
    dn_diff  = {1'b0, duty_q} - {1'b0, target_q};
    if (bypass) begin
      duty_d = target_d;
    end else if (step_en) begin
      if (duty_q < target_q) begin
        duty_d = (up_diff > STEP9) ? duty_q + STEP8 : target_q;
      end else if (duty_q > target_q) begin
        duty_d = (dn_diff > STEP9) ? duty_q - STEP8 : target_q;
      end
    end
  end

  // Target and duty registers
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
      duty_q   <= '0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
    end
  end

  assign duty           = duty_q;
  assign at_target_next = (duty_d == target_d);

endmodule

// File: rtl/rgbw_fade_slew.sv
// rtl/rgbw_fade_slew.sv - RGBW duty slew limiter top; optional gamma stage under RGBW_FADE_GAMMA_EN
module rgbw_fade_slew
  import rgbw_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  rgbw_fade_slew_if.slave       bus
);

  logic [15:0]                  cnt_q, cnt_d;
  logic                         tick;
  fade_state_e                  state_q, state_d;
  logic                         settled_q, settled_d;
  logic                         step_en;
  logic                         all_next;
  logic [3:0]                   at_next;
  logic [3:0][DUTY_W-1:0]       tgt_in;
  logic [3:0][DUTY_W-1:0]       duty;

  assign tgt_in = {bus.wTarget, bus.bTarget, bus.gTarget, bus.rTarget};
  assign tick   = (cnt_q == 16'(STEP_DIV - 1));

  // Free-running step prescaler, never restarted by new targets
  always_comb begin
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A step coinciding with a target latch is dropped so the new targets take effect first
  assign step_en  = tick && !bus.target_valid && !bus.bypass && (state_q == FADE_RAMP);
  assign all_next = &at_next;

  for (genvar c = 0; c < 4; c++) begin : g_chan
    rgbw_fade_channel #(.STEP(STEP)) u_chan (
      .clk            (clk),
      .reset          (reset),
      .load           (bus.target_valid),
      .step_en        (step_en),
      .bypass         (bus.bypass),
      .target_in      (tgt_in[c]),
      .duty           (duty[c]),
      .at_target_next (at_next[c])
    );
  end

  // FSM next state and settled flag, both judged on the post-edge channel values
  always_comb begin
    state_d   = state_q;
    settled_d = all_next;
    case (state_q)
      FADE_IDLE: if (!bus.bypass && !all_next) state_d = FADE_RAMP;
      FADE_RAMP: if (bus.bypass || all_next)   state_d = FADE_IDLE;
      default:   state_d = FADE_IDLE;
    endcase
  end

  // FSM and settled registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FADE_IDLE;
      settled_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      settled_q <= settled_d;
    end
  end

`ifdef RGBW_FADE_GAMMA_EN
  logic [3:0][DUTY_W-1:0] gam_q, gam_d;
  logic                   settled_out_q, settled_out_d;

  // Gamma-mapped copy of the ramp values, settled delayed to stay aligned
  always_comb begin
    for (int c = 0; c < 4; c++) gam_d[c] = gamma8(duty[c]);
    settled_out_d = settled_q;
  end

  // Gamma output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      gam_q         <= '0;
      settled_out_q <= 1'b1;
    end else begin
      gam_q         <= gam_d;
      settled_out_q <= settled_out_d;
    end
  end

  assign bus.rDuty   = gam_q[0];
  assign bus.gDuty   = gam_q[1];
  assign bus.bDuty   = gam_q[2];
  assign bus.wDuty   = gam_q[3];
  assign bus.settled = settled_out_q;
`else
  assign bus.rDuty   = duty[0];
  assign bus.gDuty   = duty[1];
  assign bus.bDuty   = duty[2];
  assign bus.wDuty   = duty[3];
  assign bus.settled = settled_q;
`endif

endmodule

// File: tb/tb_rgbw_fade_slew.sv
// tb/tb_rgbw_fade_slew.sv - directed self-checking bench for rgbw_fade_slew
module tb_rgbw_fade_slew;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rgbw_fade_slew_if bus ();

  rgbw_fade_slew #(
    .STEP_DIV (4),
    .STEP     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // After this returns the prescaler count is 0, so the next edge is phase 0
  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic strobe(input int r, input int g, input int b, input int w);
    bus.rTarget      = 8'(r);
    bus.gTarget      = 8'(g);
    bus.bTarget      = 8'(b);
    bus.wTarget      = 8'(w);
    bus.target_valid = 1'b1;
    cyc(1);
    bus.target_valid = 1'b0;
  endtask

  initial begin
    int exp_r [7];
    int lo;
    exp_r = '{16, 32, 48, 64, 80, 96, 100};
    bus.target_valid = 1'b0;
    bus.bypass       = 1'b0;
    bus.rTarget      = '0;
    bus.gTarget      = '0;
    bus.bTarget      = '0;
    bus.wTarget      = '0;
    @(negedge clk);

`ifdef RGBW_FADE_GAMMA_EN
    do_reset();
    bus.bypass = 1'b1;
    strobe(0, 0, 0, 0);
    cyc(1);
    check("gam_b0", bus.bDuty, 0);
    strobe(0, 0, 128, 0);
    check("gam_b128_lat1", bus.bDuty, 0);
    cyc(1);
    check("gam_b128", bus.bDuty, 64);
    strobe(0, 0, 255, 0);
    check("gam_b255_lat1", bus.bDuty, 64);
    cyc(1);
    check("gam_b255", bus.bDuty, 255);
    check("gam_settled", bus.settled, 1);
    bus.bypass = 1'b0;
    cyc(1);
`else
    // reset then idle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      check("idle_settled", bus.settled, 1);
      check("idle_duty", {bus.rDuty, bus.gDuty, bus.bDuty, bus.wDuty}, 0);
      cyc(1);
    end

    // ramp R 0 -> 100
    do_reset();
    strobe(100, 0, 0, 0);
    check("ramp_latch_r", bus.rDuty, 0);
    check("ramp_latch_settled", bus.settled, 0);
    cyc(2);
    check("ramp_pre_tick", bus.rDuty, 0);
    cyc(1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cyc(4);
      check("ramp_r", bus.rDuty, exp_r[i]);
      check("ramp_settled", bus.settled, (i == 6) ? 1 : 0);
    end

    // retarget 100 -> 40 at rDuty 64
    do_reset();
    strobe(100, 0, 0, 0);
    cyc(3);
    cyc(12);
    check("rt_at64", bus.rDuty, 64);
    strobe(40, 0, 0, 0);
    check("rt_latch_hold", bus.rDuty, 64);
    check("rt_latch_settled", bus.settled, 0);
    lo = 255;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (int'(bus.rDuty) < lo) lo = int'(bus.rDuty);
    end
    check("rt_48", bus.rDuty, 48);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (int'(bus.rDuty) < lo) lo = int'(bus.rDuty);
    end
    check("rt_40", bus.rDuty, 40);
    check("rt_settled", bus.settled, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (int'(bus.rDuty) < lo) lo = int'(bus.rDuty);
    end
    check("rt_min", lo, 40);

    // target_valid coincident with tick
    do_reset();
    cyc(3);
    strobe(0, 50, 0, 0);
    check("coin_no_step", bus.gDuty, 0);
    cyc(3);
    check("coin_hold", bus.gDuty, 0);
    cyc(1);
    check("coin_first_step", bus.gDuty, 16);

    // bypass
    do_reset();
    bus.bypass = 1'b1;
    strobe(0, 0, 0, 255);
    check("byp_w", bus.wDuty, 255);
    check("byp_settled", bus.settled, 1);
    cyc(5);
    check("byp_settled_hold", bus.settled, 1);
    bus.bypass = 1'b0;
    cyc(5);
    check("byp_off_w", bus.wDuty, 255);
    check("byp_off_settled", bus.settled, 1);

    // reset mid-ramp
    strobe(200, 0, 0, 0);
    cyc(10);
    check("mid_ramp_busy", bus.settled, 0);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_duty", {bus.rDuty, bus.gDuty, bus.bDuty, bus.wDuty}, 0);
    check("mid_rst_settled", bus.settled, 1);
    reset = 1'b0;
    cyc(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgbw_fade_slew.md
Name: rgbw_fade_slew

Overview:
- Slew-rate limiter between colorGen and pwmGen.
- Takes the four 8-bit target duties produced by colorGen and ramps the registered duties fed to pwmGen toward them at a programmable rate. This removes visible steps when SPI commands change colour or intensity.
- Runs in the clk12 domain, with its own step prescaler.

Parameters:
- STEP_DIV, 12000: clk cycles per ramp step; the default gives a 1 kHz step tick from clk12. Legal range 2..65535.
- STEP, 1: duty LSBs moved per channel per tick. Legal range 1..255.

Ports:
- clk  in  1  system clock (clk12).
- reset  in  1  synchronous, active-high reset.
- target_valid  in  1  one-cycle strobe; latch the four target inputs.
- rTarget  in  8  red target duty.
- gTarget  in  8  green target duty.
- bTarget  in  8  blue target duty.
- wTarget  in  8  white target duty.
- bypass  in  1  level; when 1, duties track targets with no ramp.
- rDuty  out  8  red duty to pwmGen.
- gDuty  out  8  green duty to pwmGen.
- bDuty  out  8  blue duty to pwmGen.
- wDuty  out  8  white duty to pwmGen.
- settled  out  1  all four duties equal their latched targets.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on posedge clk.
  - Reset is synchronous and active-high.
  - Reset values: duties 0, latched targets 0, prescaler 0, state IDLE, settled 1.
  - Reset mid-ramp abandons the ramp; outputs are 0 on the next edge.
- Target latch: on a target_valid edge, latch all four targets; settled drops the same edge if any target differs from its current duty.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps.
  - tick is high on the cycle where count == STEP_DIV-1.
  - The prescaler free-runs in every state and is not restarted by target_valid.
- State machine:
  - IDLE -> RAMP when any latched target differs from its duty.
  - RAMP -> IDLE on the edge where the last channel reaches its target; settled rises on that same edge.
- Per channel on a tick in RAMP:
  - If duty < target: duty += min(STEP, target - duty).
  - If duty > target: duty -= min(STEP, duty - target).
  - Otherwise hold.
  - Never overshoot; use 9-bit difference arithmetic so there is no wrap at 0 or 255.
- Retarget mid-ramp: latch new targets and continue from the current duties with no restart. Channels whose direction flips reverse on the next tick.
- target_valid and tick on the same cycle: the targets latch and the step is skipped on that edge. The next tick steps toward the new targets.
- Bypass:
  - While bypass=1, each duty equals its latched target (1-cycle latency from target_valid), state is IDLE and settled=1. The prescaler keeps running.
  - On bypass 1->0, duties are already equal to the targets, so no ramp occurs.
- Latency: duty outputs are registered. The first change after target_valid appears on the first tick edge that does not coincide with the latch edge.

Optional Feature:
- Macro: RGBW_FADE_GAMMA_EN.
- Defined:
  - Each output is a registered gamma-approximated copy of the internal ramp value: out = (d*(d+1))>>8.
  - Fixed points: 0->0, 128->64, 255->255.
  - Adds one cycle of latency to the outputs.
  - settled asserts one cycle after the internal values settle, so it stays aligned with the outputs.
- Undefined: outputs are the internal ramp registers directly, with no extra latency.

Decomposition:
- Package rgbw_pkg:
  - state encoding (FADE_IDLE, FADE_RAMP);
  - DUTY_W = 8;
  - default STEP_DIV / STEP constants.
- One sub-module, rgbw_fade_channel, instantiated four times. It holds:
  - latched target;
  - duty register;
  - clamp-step logic;
  - an at_target flag.
- The top level holds the prescaler, the FSM, settled, and the optional gamma stage.

Test Plan (benches use STEP_DIV=4, STEP=16, macro undefined unless stated):
- Reset then idle -> all duties 0, settled=1 throughout.
- target_valid with R=100, others 0 -> rDuty goes 16,32,...,96,100 on successive ticks (7 ticks). settled rises on the edge rDuty becomes 100.
- From R=100, retarget R=40 mid-ramp at rDuty=64 -> 48,40, then IDLE. No value below 40 appears.
- target_valid coincident with tick -> no step on that edge; the first step comes 4 cycles later.
- bypass=1, target W=255 -> wDuty=255 one cycle after the strobe, settled stays 1. Reset asserted mid-ramp -> all outputs 0 the next cycle.
- RGBW_FADE_GAMMA_EN defined, bypass=1, B targets 0/128/255 -> bDuty 0/64/255, each two cycles after the strobe.
